// File: rtl/pipe_ctrl_v2.sv
// Pipeline stall merge and exception/ERET flush sequencer.
// Optional stall-cycle performance counter is enabled by defining CTRL_PERF_CNT_EN.
//
// state | meaning
// IDLE  | stalls follow requests; waiting for an acceptable exception
// FLUSH | flush asserted, new_pc holds the redirect target, stalls suppressed
module pipe_ctrl_v2 #(
   parameter int unsigned        STAGES       = 9,
   parameter int unsigned        NREQ         = 6,
   parameter logic [NREQ*4-1:0]  REQ_DEPTH    = {4'd7, 4'd8, 4'd4, 4'd3, 4'd2, 4'd3},
   parameter int unsigned        EXC_STAGE    = 5,
   parameter int unsigned        FLUSH_CYCLES = 1,
   parameter logic [31:0]        EXC_VECTOR   = 32'hBFC00380,
   parameter logic [31:0]        ERET_CODE    = 32'h0000000E
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   stallreq,
   input  logic [31:0]       excepttype_i,
   input  logic [31:0]       cp0_epc_i,
   output logic [STAGES-1:0] stall,
   output logic              flush,
   output logic [31:0]       new_pc,
   output logic              busy,
   output logic [31:0]       perf_stall_cnt
);

   typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       tgt_q, tgt_d;
   logic [STAGES-1:0] stall_merged;
   logic              accept;

   // Each request stalls a prefix of stages; OR-ing prefixes leaves the deepest one.
   always_comb begin
      stall_merged = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (stallreq[i]) begin
            for (int k = 0; k < int'(STAGES); k++) begin
               if (k <= int'(REQ_DEPTH[i*4 +: 4])) stall_merged[k] = 1'b1;
            end
         end
      end
   end

   assign accept = (state_q == IDLE) && (excepttype_i != 32'h0) && !stall_merged[EXC_STAGE];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = FLUSH;
               cnt_d   = CNT_LOAD;
               tgt_d   = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
            end
         end
         FLUSH: begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
               tgt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
      end
   end

   assign flush  = (state_q == FLUSH);
   assign busy   = (state_q == FLUSH);
   assign new_pc = tgt_q;
   assign stall  = (rst || state_q == FLUSH) ? '0 : stall_merged;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk) begin
      if (rst)         perf_q <= '0;
      else if (|stall) perf_q <= perf_q + 32'd1;
   end

   assign perf_stall_cnt = perf_q;
`else
   assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Randomized self-checking bench for pipe_ctrl_v2; two instances (1-cycle and
// 3-cycle flush) share stimulus and are compared against a behavioural model.
module tb_pipe_ctrl_v2;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stallreq;
   logic [31:0] excepttype_i;
   logic [31:0] cp0_epc_i;

   logic [8:0]  stall_o [2];
   logic        flush_o [2];
   logic [31:0] new_pc_o [2];
   logic        busy_o [2];
   logic [31:0] perf_o [2];

   int n_checks = 0;
   int n_errors = 0;

   // Model state per instance
   int          fc [2]    = '{1, 3};
   int          depth [6] = '{3, 2, 3, 4, 8, 7};
   bit          m_busy [2];
   int          m_left [2];
   logic [31:0] m_tgt [2];
   logic [31:0] m_perf [2];

   always #5 clk = ~clk;

   pipe_ctrl_v2 u_dut (
      .clk(clk), .rst(rst), .stallreq(stallreq), .excepttype_i(excepttype_i),
      .cp0_epc_i(cp0_epc_i), .stall(stall_o[0]), .flush(flush_o[0]),
      .new_pc(new_pc_o[0]), .busy(busy_o[0]), .perf_stall_cnt(perf_o[0])
   );

   pipe_ctrl_v2 #(.FLUSH_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .stallreq(stallreq), .excepttype_i(excepttype_i),
      .cp0_epc_i(cp0_epc_i), .stall(stall_o[1]), .flush(flush_o[1]),
      .new_pc(new_pc_o[1]), .busy(busy_o[1]), .perf_stall_cnt(perf_o[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] ref_merge(input logic [5:0] req);
      int deepest = -1;
      for (int i = 0; i < 6; i++)
         if (req[i] && depth[i] > deepest) deepest = depth[i];
      if (deepest < 0) return 9'h0;
      return 9'((1 << (deepest + 1)) - 1);
   endfunction

   // Apply one cycle of inputs, check all outputs mid-cycle, then advance the model.
   task automatic step(input logic r, input logic [5:0] req,
                       input logic [31:0] exc, input logic [31:0] epc);
      logic [8:0]  mrg;
      logic [8:0]  exp_stall;
      logic [31:0] exp_perf;
      @(negedge clk);
      rst = r; stallreq = req; excepttype_i = exc; cp0_epc_i = epc;
      #1;
      mrg = ref_merge(req);
      for (int j = 0; j < 2; j++) begin
         exp_stall = (r || m_busy[j]) ? 9'h0 : mrg;
`ifdef CTRL_PERF_CNT_EN
         exp_perf = m_perf[j];
`else
         exp_perf = 32'h0;
`endif
         chk($sformatf("stall%0d", j),  32'(stall_o[j]),  32'(exp_stall));
         chk($sformatf("flush%0d", j),  32'(flush_o[j]),  32'(m_busy[j]));
         chk($sformatf("busy%0d", j),   32'(busy_o[j]),   32'(m_busy[j]));
         chk($sformatf("new_pc%0d", j), new_pc_o[j],      m_busy[j] ? m_tgt[j] : 32'h0);
         chk($sformatf("perf%0d", j),   perf_o[j],        exp_perf);
         if (r) begin
            m_busy[j] = 1'b0;
            m_perf[j] = 32'h0;
         end else if (m_busy[j]) begin
            m_left[j]--;
            if (m_left[j] == 0) m_busy[j] = 1'b0;
         end else begin
            if (exp_stall != 9'h0) m_perf[j] = m_perf[j] + 32'd1;
            if (exc != 32'h0 && !mrg[5]) begin
               m_busy[j] = 1'b1;
               m_left[j] = fc[j];
               m_tgt[j]  = (exc == 32'h0000000E) ? epc : 32'hBFC00380;
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; stallreq = 6'h3F; excepttype_i = 32'h1; cp0_epc_i = 32'h0;
      for (int j = 0; j < 2; j++) begin
         m_busy[j] = 1'b0; m_left[j] = 0; m_tgt[j] = 32'h0; m_perf[j] = 32'h0;
      end
      repeat (2) @(posedge clk);

      // reset held with all requests and a pending exception
      repeat (3) step(1'b1, 6'h3F, 32'h1, 32'h0);

      // prefix merge
      step(1'b0, 6'b000100, 32'h0, 32'h0);
      chk("plan_merge_a", 32'(stall_o[0]), 32'h00F);
      step(1'b0, 6'b010101, 32'h0, 32'h0);
      chk("plan_merge_b", 32'(stall_o[0]), 32'h1FF);
      step(1'b0, 6'b000000, 32'h0, 32'h0);

      // plain exception
      step(1'b0, 6'h0, 32'h4, 32'h0);
      step(1'b0, 6'h0, 32'h0, 32'h0);
      chk("plan_exc_flush", 32'(flush_o[0]), 32'h1);
      chk("plan_exc_pc", new_pc_o[0], 32'hBFC00380);
      step(1'b0, 6'h0, 32'h0, 32'h0);
      chk("plan_exc_end", 32'(flush_o[0]), 32'h0);
      repeat (3) step(1'b0, 6'h0, 32'h0, 32'h0);

      // ERET held off by a stall covering the exception stage
      repeat (3) step(1'b0, 6'b010000, 32'hE, 32'h80001234);
      step(1'b0, 6'h0, 32'hE, 32'h80001234);
      step(1'b0, 6'h0, 32'h0, 32'h0);
      chk("plan_eret_pc", new_pc_o[0], 32'h80001234);
      repeat (4) step(1'b0, 6'h0, 32'h0, 32'h0);

      // 3-cycle flush overriding all stall requests; back-to-back acceptance on return
      step(1'b0, 6'h0, 32'h4, 32'h0);
      repeat (3) step(1'b0, 6'h3F, 32'h0, 32'h0);
      step(1'b0, 6'h3F, 32'h0, 32'h0);
      chk("plan_fc3_resume", 32'(stall_o[1]), 32'h1FF);
      step(1'b0, 6'h0, 32'h8, 32'h0);
      repeat (4) step(1'b0, 6'h0, 32'h0, 32'h0);

      // mid-flush reset
      step(1'b0, 6'h0, 32'hE, 32'h12345678);
      step(1'b0, 6'h0, 32'h0, 32'h0);
      step(1'b1, 6'h0, 32'h0, 32'h0);
      step(1'b0, 6'h0, 32'h0, 32'h0);
      chk("plan_rst_flush", 32'(flush_o[1]), 32'h0);

      // stall-cycle counting
      step(1'b1, 6'h0, 32'h0, 32'h0);
      repeat (5) step(1'b0, 6'h1, 32'h0, 32'h0);
      step(1'b0, 6'h0, 32'h0, 32'h0);
`ifdef CTRL_PERF_CNT_EN
      chk("plan_perf5", perf_o[0], 32'd5);
`endif
      step(1'b1, 6'h0, 32'h0, 32'h0);
      step(1'b0, 6'h0, 32'h0, 32'h0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         logic        r;
         logic [5:0]  req;
         logic [31:0] exc;
         int          sel;
         r   = ($urandom_range(0, 49) == 0);
         req = 6'h0;
         for (int b = 0; b < 6; b++) req[b] = ($urandom_range(0, 5) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 6)       exc = 32'h0;
         else if (sel < 8)  exc = 32'h0000000E;
         else               exc = $urandom;
         step(r, req, exc, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
